// File: rtl/game_pkg.sv
// Shared types and defaults for the bomb-dismantlement round controller.
package game_pkg;

  localparam int unsigned SEED_W_DEF        = 5;
  localparam int unsigned RESULT_CYCLES_DEF = 250_000_000;
  localparam int unsigned SCORE_W           = 8;

  typedef enum logic [2:0] {
    S_OFF   = 3'd0,
    S_IDLE  = 3'd1,
    S_SHOW  = 3'd2,
    S_ARMED = 3'd3,
    S_WIN   = 3'd4,
    S_LOSE  = 3'd5
  } state_e;

  typedef struct packed {
    logic sub_rst;
    logic showing;
    logic start;
    logic start_input;
    logic bomb_switch;
    logic win;
    logic lose;
  } enables_t;

  // Moore decode of datapath enables for a given round state.
  function automatic enables_t decode_enables(state_e s);
    enables_t e;
    e = '0;
    case (s)
      S_IDLE:  begin e.sub_rst = 1'b1; e.bomb_switch = 1'b1; end
      S_SHOW:  begin e.showing = 1'b1; e.bomb_switch = 1'b1; end
      S_ARMED: begin e.start = 1'b1; e.start_input = 1'b1; e.bomb_switch = 1'b1; end
      S_WIN:   e.win = 1'b1;
      S_LOSE:  e.lose = 1'b1;
      default: e.sub_rst = 1'b1;
    endcase
    return e;
  endfunction

endpackage

// File: rtl/game_sequencer_if.sv
// Control bundle between the round sequencer and the game datapath blocks.
// SCORE_EN adds the 8-bit win score output.
interface game_sequencer_if
  import game_pkg::*;
#(
  parameter int unsigned SEED_W = SEED_W_DEF
) ();

  logic              SW7;
  logic              BTN1;
  logic              end_of_show;
  logic              success;
  logic              fail;
  logic              repeat_req;
  logic              sub_rst;
  logic [SEED_W-1:0] random;
  logic              showing;
  logic              start;
  logic              start_input;
  logic              bomb_switch;
  logic              win;
  logic              lose;
`ifdef SCORE_EN
  logic [SCORE_W-1:0] score;
`endif

  modport master (
    input  SW7, BTN1, end_of_show, success, fail, repeat_req,
`ifdef SCORE_EN
    output score,
`endif
    output sub_rst, random, showing, start, start_input, bomb_switch, win, lose
  );

  modport slave (
`ifdef SCORE_EN
    input  score,
`endif
    input  sub_rst, random, showing, start, start_input, bomb_switch, win, lose,
    output SW7, BTN1, end_of_show, success, fail, repeat_req
  );

endinterface

// File: rtl/game_sequencer_btn_edge.sv
// Registered rising-edge detector; the pulse appears one cycle after the edge is sampled.
module btn_edge (
  input  logic clk,
  input  logic rst_p,
  input  logic btn_i,
  output logic rise_o
);

  logic prev_q;
  logic rise_q;

  always_ff @(posedge clk) begin
    if (rst_p) begin
      prev_q <= 1'b0;
      rise_q <= 1'b0;
    end else begin
      prev_q <= btn_i;
      rise_q <= btn_i & ~prev_q;
    end
  end

  assign rise_o = rise_q;

endmodule

// File: rtl/game_sequencer.sv
// Round controller: sequences show/armed/result phases and captures the round seed.
// Optional SCORE_EN adds a saturating win counter on the score output.
module game_sequencer
  import game_pkg::*;
#(
  parameter int unsigned RESULT_CYCLES = RESULT_CYCLES_DEF,
  parameter int unsigned SEED_W        = SEED_W_DEF
) (
  input logic              clk,
  input logic              rst_p,
  game_sequencer_if.master bus
);

  localparam int unsigned TMR_W = (RESULT_CYCLES > 1) ? $clog2(RESULT_CYCLES) : 1;

  state_e            state_q;
  enables_t          en_q;
  logic [SEED_W-1:0] seed_q;
  logic [SEED_W-1:0] random_q;
  logic [TMR_W-1:0]  timer_q;
  logic              btn_rise;
  logic              timer_done;

  btn_edge u_btn_edge (
    .clk   (clk),
    .rst_p (rst_p),
    .btn_i (bus.BTN1),
    .rise_o(btn_rise)
  );

  assign timer_done = (timer_q == TMR_W'(RESULT_CYCLES - 1));

  // Enables are decoded from the settled state, so they trail a transition by one cycle.
  always_ff @(posedge clk) begin
    if (rst_p) begin
      state_q  <= S_OFF;
      en_q     <= decode_enables(S_OFF);
      seed_q   <= '0;
      random_q <= '0;
      timer_q  <= '0;
    end else begin
      seed_q  <= seed_q + SEED_W'(1);
      en_q    <= decode_enables(state_q);
      timer_q <= '0;
      if (!bus.SW7) begin
        state_q <= S_OFF;
      end else begin
        case (state_q)
          S_OFF:  state_q <= S_IDLE;
          S_IDLE: begin
            if (btn_rise) begin
              state_q  <= S_SHOW;
              random_q <= seed_q;
            end
          end
          S_SHOW: begin
            if (bus.end_of_show) state_q <= S_ARMED;
          end
          S_ARMED: begin
            if (bus.success)   state_q <= S_WIN;
            else if (bus.fail) state_q <= S_LOSE;
          end
          S_WIN, S_LOSE: begin
            if (timer_done || bus.repeat_req || btn_rise) state_q <= S_IDLE;
            else                                          timer_q <= timer_q + TMR_W'(1);
          end
          default: state_q <= S_OFF;
        endcase
      end
    end
  end

  assign bus.sub_rst     = en_q.sub_rst;
  assign bus.showing     = en_q.showing;
  assign bus.start       = en_q.start;
  assign bus.start_input = en_q.start_input;
  assign bus.bomb_switch = en_q.bomb_switch;
  assign bus.win         = en_q.win;
  assign bus.lose        = en_q.lose;
  assign bus.random      = random_q;

`ifdef SCORE_EN
  logic [SCORE_W-1:0] score_q;

  // Counts ARMED->WIN transitions; powering off starts a fresh session.
  always_ff @(posedge clk) begin
    if (rst_p || !bus.SW7) begin
      score_q <= '0;
    end else if (state_q == S_ARMED && bus.success && score_q != '1) begin
      score_q <= score_q + SCORE_W'(1);
    end
  end

  assign bus.score = score_q;
`endif

endmodule
